// File: rtl/draw_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// draw_cmd_scheduler
//   Buffers UART command packets in a small FIFO and arbitrates them against
//   game-logic draw requests, issuing one command at a time to the shared
//   pixel-drawing engine and tracking the engine's busy handshake.
//
// Ports
//   i_clk          system clock, rising edge
//   n_btn_rst      asynchronous active-low reset
//   i_pkt_valid    single-cycle packet strobe from the aggregator (no backpressure)
//   i_pkt_sym      symbol-mode flag, sampled with i_pkt_valid
//   i_pkt_data     packet payload, sampled with i_pkt_valid
//   i_game_req     game draw request, level, held until o_game_ack
//   i_game_data    game command, stable while i_game_req is high
//   i_vblank       vertical blanking; gives game requests priority in IDLE
//   i_draw_busy    draw engine busy
//   o_draw_start   one-cycle command-issue pulse
//   o_draw_src     source of issued command (0 = UART, 1 = game)
//   o_draw_sym     symbol flag of issued command (0 for game commands)
//   o_draw_data    issued payload, held until the next grant
//   o_game_ack     one-cycle ack, coincident with o_draw_start for game issues
//   o_fifo_count   current FIFO occupancy
//   o_overflow     sticky packet-dropped flag
//   o_drop_cnt     dropped-packet count, saturating at 255
// -----------------------------------------------------------------------------
module draw_cmd_scheduler #(
  parameter int unsigned PAYLD_BITS = 56,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          n_btn_rst,
  input  logic                          i_pkt_valid,
  input  logic                          i_pkt_sym,
  input  logic [PAYLD_BITS-1:0]         i_pkt_data,
  input  logic                          i_game_req,
  input  logic [PAYLD_BITS-1:0]         i_game_data,
  input  logic                          i_vblank,
  input  logic                          i_draw_busy,
  output logic                          o_draw_start,
  output logic                          o_draw_src,
  output logic                          o_draw_sym,
  output logic [PAYLD_BITS-1:0]         o_draw_data,
  output logic                          o_game_ack,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow,
  output logic [7:0]                    o_drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PAYLD_BITS + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, ARM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      arm_cnt_q, arm_cnt_d;
  logic            last_src_q;
  logic            grant_u, grant_g;
  logic            pop, push, full;
  logic            u_pend, g_pend;

  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [EW-1:0]   rd_entry;

  assign full     = (o_fifo_count == CW'(FIFO_DEPTH));
  assign u_pend   = (o_fifo_count != '0);
  assign g_pend   = i_game_req;
  assign rd_entry = fifo_mem[rd_ptr];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push     = i_pkt_valid && (!full || pop);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      state_q   <= IDLE;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, grant decision and issue-cycle strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    arm_cnt_d    = arm_cnt_q;
    grant_u      = 1'b0;
    grant_g      = 1'b0;
    o_draw_start = 1'b0;
    o_game_ack   = 1'b0;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        // Vblank favours the game; otherwise round-robin on the last winner.
        if (g_pend && (i_vblank || !u_pend || !last_src_q)) begin
          grant_g = 1'b1;
        end else if (u_pend) begin
          grant_u = 1'b1;
        end
        if (grant_g || grant_u) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_draw_start = 1'b1;
        if (o_draw_src) begin
          o_game_ack = 1'b1;
        end else begin
          pop = 1'b1;
        end
        arm_cnt_d = '0;
        state_d   = ARM;
      end
      ARM: begin
        // Engine gets four cycles to raise busy before the command is
        // considered already complete.
        if (i_draw_busy) begin
          state_d = DRAIN;
        end else if (arm_cnt_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      DRAIN: begin
        if (!i_draw_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issued-command registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      o_draw_src  <= 1'b0;
      o_draw_sym  <= 1'b0;
      o_draw_data <= '0;
      last_src_q  <= 1'b1;
    end else if (grant_g) begin
      o_draw_src  <= 1'b1;
      o_draw_sym  <= 1'b0;
      o_draw_data <= i_game_data;
      last_src_q  <= 1'b1;
    end else if (grant_u) begin
      o_draw_src  <= 1'b0;
      o_draw_sym  <= rd_entry[PAYLD_BITS];
      o_draw_data <= rd_entry[PAYLD_BITS-1:0];
      last_src_q  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // UART packet FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {i_pkt_sym, i_pkt_data};
    end
  end

  always_ff @(posedge i_clk or negedge n_btn_rst) begin
    if (!n_btn_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
      o_overflow   <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   o_fifo_count <= o_fifo_count + CW'(1);
        2'b01:   o_fifo_count <= o_fifo_count - CW'(1);
        default: o_fifo_count <= o_fifo_count;
      endcase
      if (i_pkt_valid && !push) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != 8'hFF) begin
          o_drop_cnt <= o_drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule
